// File: rtl/inv_round_sequencer.sv
// AES inverse-cipher round sequencer: walks the round-key index from NUM_ROUNDS down to 0,
// presenting one round command per index over a valid/ack handshake.
module inv_round_sequencer #(
   parameter int unsigned NUM_ROUNDS = 10,
   parameter int unsigned CNT_WIDTH  = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic                 round_ack,
   output logic                 round_valid,
   output logic [CNT_WIDTH-1:0] round_idx,
   output logic                 sub_en,
   output logic                 mix_en,
   output logic                 first_round,
   output logic                 busy,
   output logic                 done
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam logic [CNT_WIDTH-1:0] LP_NR   = CNT_WIDTH'(NUM_ROUNDS);
   localparam logic [CNT_WIDTH-1:0] LP_ZERO = '0;

   logic [1:0]           r_state;
   logic [1:0]           w_state_d;
   logic [CNT_WIDTH-1:0] r_idx;
   logic [CNT_WIDTH-1:0] w_idx_d;
   logic                 w_idx_zero;

   assign w_idx_zero = (r_idx == LP_ZERO);

   // abort overrides every transition, including an ack in the same cycle
   always_comb begin
      w_state_d = r_state;
      w_idx_d   = r_idx;
      if (abort) begin
         w_state_d = ST_IDLE;
         w_idx_d   = LP_ZERO;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  w_state_d = ST_ISSUE;
                  w_idx_d   = LP_NR;
               end
            end
            ST_ISSUE: begin
               if (round_ack) begin
                  if (w_idx_zero) begin
                     w_state_d = ST_DONE;
                  end else begin
                     w_idx_d = r_idx - CNT_WIDTH'(1);
                  end
               end
            end
            ST_DONE: begin
               w_state_d = ST_IDLE;
               w_idx_d   = LP_ZERO;
            end
            default: begin
               w_state_d = ST_IDLE;
               w_idx_d   = LP_ZERO;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_idx   <= LP_ZERO;
      end else begin
         r_state <= w_state_d;
         r_idx   <= w_idx_d;
      end
   end

   assign round_valid = (r_state == ST_ISSUE);
   assign round_idx   = r_idx;
   assign busy        = (r_state != ST_IDLE);
   assign done        = (r_state == ST_DONE);
   assign sub_en      = round_valid && (r_idx < LP_NR);
   assign mix_en      = round_valid && (r_idx < LP_NR) && !w_idx_zero;
   assign first_round = round_valid && (r_idx == LP_NR);

endmodule

// File: tb/tb_inv_round_sequencer.sv
// Bench for inv_round_sequencer: NUM_ROUNDS=10 and 14 instances on shared stimulus, checked
// every cycle against a beat-counting model plus hand-computed cycle tables.
module tb_inv_round_sequencer;

   logic       clk;
   logic       rst;
   logic       start;
   logic       abort;
   logic       round_ack;
   logic       vld[2];
   logic [4:0] idx[2];
   logic       sub[2];
   logic       mix[2];
   logic       first[2];
   logic       bsy[2];
   logic       dn[2];

   int total;
   int bad;
   bit run_cmp;

   inv_round_sequencer #(.NUM_ROUNDS(10), .CNT_WIDTH(5)) dut10 (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .round_ack(round_ack),
      .round_valid(vld[0]), .round_idx(idx[0]), .sub_en(sub[0]), .mix_en(mix[0]),
      .first_round(first[0]), .busy(bsy[0]), .done(dn[0])
   );

   inv_round_sequencer #(.NUM_ROUNDS(14), .CNT_WIDTH(5)) dut14 (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .round_ack(round_ack),
      .round_valid(vld[1]), .round_idx(idx[1]), .sub_en(sub[1]), .mix_en(mix[1]),
      .first_round(first[1]), .busy(bsy[1]), .done(dn[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: counts accepted commands in the current block; the index is NR minus that count.
   int nrs[2] = '{10, 14};
   bit m_act[2];
   bit m_done[2];
   int m_beats[2];

   always @(posedge clk or posedge rst) begin
      for (int i = 0; i < 2; i++) begin
         if (rst || abort) begin
            m_act[i]   <= 1'b0;
            m_done[i]  <= 1'b0;
            m_beats[i] <= 0;
         end else if (m_done[i]) begin
            m_done[i] <= 1'b0;
         end else if (m_act[i]) begin
            if (round_ack) begin
               if (m_beats[i] == nrs[i]) begin
                  m_act[i]   <= 1'b0;
                  m_done[i]  <= 1'b1;
                  m_beats[i] <= 0;
               end else begin
                  m_beats[i] <= m_beats[i] + 1;
               end
            end
         end else if (start) begin
            m_act[i]   <= 1'b1;
            m_beats[i] <= 0;
         end
      end
   end

   always @(negedge clk) begin
      if (run_cmp) begin
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("m%0d.valid", i), int'(vld[i]), int'(m_act[i]));
            chk($sformatf("m%0d.idx", i), int'(idx[i]), m_act[i] ? nrs[i] - m_beats[i] : 0);
            chk($sformatf("m%0d.first", i), int'(first[i]), int'(m_act[i] && m_beats[i] == 0));
            chk($sformatf("m%0d.sub", i), int'(sub[i]), int'(m_act[i] && m_beats[i] > 0));
            chk($sformatf("m%0d.mix", i), int'(mix[i]),
                int'(m_act[i] && m_beats[i] > 0 && m_beats[i] < nrs[i]));
            chk($sformatf("m%0d.busy", i), int'(bsy[i]), int'(m_act[i] || m_done[i]));
            chk($sformatf("m%0d.done", i), int'(dn[i]), int'(m_done[i]));
         end
      end
   end

   // Inputs for the next cycle, applied shortly after the active edge.
   task automatic step(input bit s, input bit a, input bit k);
      @(posedge clk);
      #2;
      start     = s;
      abort     = a;
      round_ack = k;
   endtask

   int exp_idx[14] = '{10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 0, 0, 0};
   int done_cnt;
   int beats;

   initial begin
      total = 0;
      bad = 0;
      run_cmp = 1'b0;
      rst = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      round_ack = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      run_cmp = 1'b1;
      step(0, 0, 0);
      chk("reset.busy", int'(bsy[0]), 0);
      chk("reset.idx", int'(idx[0]), 0);
      chk("reset.valid", int'(vld[0]), 0);

      // Nominal run, ack tied high; cycle c is the c-th cycle after start was sampled
      step(1, 0, 1);
      for (int c = 1; c <= 13; c++) begin
         step(0, 0, 1);
         chk($sformatf("nom.c%0d.valid", c), int'(vld[0]), int'(c <= 11));
         chk($sformatf("nom.c%0d.idx", c), int'(idx[0]), exp_idx[c-1]);
         chk($sformatf("nom.c%0d.first", c), int'(first[0]), int'(c == 1));
         chk($sformatf("nom.c%0d.mix", c), int'(mix[0]), int'(c >= 2 && c <= 10));
         chk($sformatf("nom.c%0d.sub", c), int'(sub[0]), int'(c >= 2 && c <= 11));
         chk($sformatf("nom.c%0d.done", c), int'(dn[0]), int'(c == 12));
         chk($sformatf("nom.c%0d.busy", c), int'(bsy[0]), int'(c <= 12));
      end
      repeat (6) step(0, 0, 0);

      // Backpressure: three ack-low cycles while idx=5
      step(1, 0, 1);
      for (int c = 1; c <= 5; c++) step(0, 0, 1);
      for (int c = 6; c <= 8; c++) begin
         step(0, 0, 0);
         chk("bp.idx", int'(idx[0]), 5);
         chk("bp.mix", int'(mix[0]), 1);
         chk("bp.sub", int'(sub[0]), 1);
      end
      for (int c = 9; c <= 15; c++) begin
         step(0, 0, 1);
         chk($sformatf("bp.c%0d.done", c), int'(dn[0]), int'(c == 15));
      end
      repeat (12) step(0, 0, 1);

      // Abort together with ack while idx=3: no count, no done
      step(1, 0, 1);
      for (int c = 1; c <= 7; c++) step(0, 0, 1);
      step(1'b0, 1'b1, 1'b1);
      chk("abort.idx_before", int'(idx[0]), 3);
      step(0, 0, 1);
      chk("abort.valid", int'(vld[0]), 0);
      chk("abort.idx", int'(idx[0]), 0);
      chk("abort.busy14", int'(bsy[1]), 0);
      done_cnt = 0;
      for (int c = 0; c < 4; c++) begin
         step(0, 0, 1);
         done_cnt += int'(dn[0]);
      end
      chk("abort.no_done", done_cnt, 0);

      // Fresh start, with a start pulse while busy that must be ignored
      step(1, 0, 1);
      step(0, 0, 1);
      chk("restart.idx10", int'(idx[0]), 10);
      chk("restart.idx14", int'(idx[1]), 14);
      done_cnt = 0;
      for (int c = 2; c <= 20; c++) begin
         step(c == 5, 0, 1);
         done_cnt += int'(dn[0]);
      end
      chk("ignored_start.single_done", done_cnt, 1);
      chk("ignored_start.idle", int'(bsy[0]), 0);

      // start+abort in IDLE stays idle
      step(1, 1, 0);
      step(0, 0, 0);
      chk("start_abort.busy10", int'(bsy[0]), 0);
      chk("start_abort.busy14", int'(bsy[1]), 0);

      // NUM_ROUNDS=14: 15 valid beats, done @16, start in the next cycle accepted
      step(1, 0, 1);
      beats = 0;
      for (int c = 1; c <= 16; c++) begin
         step(0, 0, 1);
         beats += int'(vld[1]);
         if (c == 1) chk("nr14.first_idx", int'(idx[1]), 14);
         chk($sformatf("nr14.c%0d.done", c), int'(dn[1]), int'(c == 16));
      end
      chk("nr14.beats", beats, 15);
      step(1, 0, 1);
      chk("nr14.idle_after_done", int'(bsy[1]), 0);
      step(0, 0, 1);
      chk("nr14.restart_valid", int'(vld[1]), 1);
      chk("nr14.restart_idx", int'(idx[1]), 14);

      // Async reset mid-ISSUE
      repeat (3) step(0, 0, 1);
      #1 rst = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("rst%0d.valid", i), int'(vld[i]), 0);
         chk($sformatf("rst%0d.idx", i), int'(idx[i]), 0);
         chk($sformatf("rst%0d.busy", i), int'(bsy[i]), 0);
         chk($sformatf("rst%0d.sub", i), int'(sub[i]), 0);
      end
      step(0, 0, 1);
      rst = 1'b0;
      repeat (3) step(0, 0, 1);
      chk("post_rst.busy", int'(bsy[0]), 0);
      chk("post_rst.idx", int'(idx[0]), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
